// File: rtl/pm32.sv
// rtl/pm32.sv - 3-stage pipelined 32x32->64 multiplier built from four 16x16 partial products.
// Optional macro PM32_SIGNED_EN switches operands and product to two's complement.
module pm32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [63:0] c
);

`ifdef PM32_SIGNED_EN
  localparam logic SIGNED_MODE = 1'b1;
`else
  localparam logic SIGNED_MODE = 1'b0;
`endif

  // Stage 1: operand capture
  logic [31:0] a_q, b_q;
  logic        v1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  // Halves are widened to 17-bit signed so one datapath serves both modes:
  // the upper half's extra bit is its sign in signed mode and zero otherwise.
  logic signed [16:0] a_lo, a_hi, b_lo, b_hi;
  logic signed [33:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;
  logic signed [33:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;

  assign a_lo   = {1'b0, a_q[15:0]};
  assign b_lo   = {1'b0, b_q[15:0]};
  assign a_hi   = {SIGNED_MODE & a_q[31], a_q[31:16]};
  assign b_hi   = {SIGNED_MODE & b_q[31], b_q[31:16]};
  assign a_lo_x = 34'(a_lo);
  assign a_hi_x = 34'(a_hi);
  assign b_lo_x = 34'(b_lo);
  assign b_hi_x = 34'(b_hi);

  assign pp_ll_d = a_lo_x * b_lo_x;
  assign pp_lh_d = a_lo_x * b_hi_x;
  assign pp_hl_d = a_hi_x * b_lo_x;
  assign pp_hh_d = a_hi_x * b_hi_x;

  // Stage 2: partial products
  logic signed [33:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  logic               v2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
      pp_hh_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        pp_ll_q <= pp_ll_d;
        pp_lh_q <= pp_lh_d;
        pp_hl_q <= pp_hl_d;
        pp_hh_q <= pp_hh_d;
      end
    end
  end

  logic signed [63:0] mid_sum;
  logic signed [63:0] c_d;

  assign mid_sum = 64'(pp_lh_q) + 64'(pp_hl_q);
  assign c_d     = (64'(pp_hh_q) <<< 32) + (mid_sum <<< 16) + 64'(pp_ll_q);

  // Stage 3: c only moves on a valid slot, so it holds through bubbles
  logic [63:0] c_q;
  logic        v3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q  <= '0;
      v3_q <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        c_q <= c_d;
      end
    end
  end

  assign c         = c_q;
  assign out_valid = v3_q;

endmodule

// File: tb/tb_pm32.sv
// tb/tb_pm32.sv - self-checking bench for pm32 (queue-based product model plus literal checks).
module tb_pm32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic [63:0] c;

  always #5 clk = ~clk;

  pm32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .c        (c)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
`ifdef PM32_SIGNED_EN
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
`else
    sx = {32'b0, x};
    sy = {32'b0, y};
`endif
    return sx * sy;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model: each accepted operation is due two edges after its sampling edge.
  typedef struct {
    int          due;
    logic [63:0] p;
  } pend_t;

  pend_t       pq[$];
  int          mcyc = 0;
  logic        exp_v = 1'b0;
  logic [63:0] exp_c = '0;

  always @(posedge clk or negedge rst_n) begin
    pend_t e;
    if (!rst_n) begin
      pq.delete();
      exp_v = 1'b0;
      exp_c = '0;
    end else begin
      exp_v = 1'b0;
      if (pq.size() > 0 && pq[0].due == mcyc) begin
        exp_v = 1'b1;
        exp_c = pq[0].p;
        void'(pq.pop_front());
      end
      if (in_valid) begin
        e.due = mcyc + 2;
        e.p   = ref_mul(a, b);
        pq.push_back(e);
      end
      mcyc++;
    end
  end

  logic [63:0] got_c[$];
  int          got_cyc[$];
  bit          checking = 1'b0;

  always @(negedge clk) begin
    if (checking) begin
      chk($sformatf("out_valid@%0d", mcyc), {63'b0, out_valid}, {63'b0, exp_v});
      chk($sformatf("c@%0d", mcyc), c, exp_c);
      if (out_valid) begin
        got_c.push_back(c);
        got_cyc.push_back(mcyc - 1);
      end
    end
  end

  function automatic logic [63:0] got_at(input int i);
    if (i < got_c.size()) return got_c[i];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < got_cyc.size()) return got_cyc[i];
    return -1000;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic clear_log();
    got_c.delete();
    got_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    // Reset held with a live operation on the inputs
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 32'd5;
    b = 32'd7;
    repeat (2) @(posedge clk);
    #2;
    checking = 1'b1;
    repeat (3) step();
    chk("rst_c", c, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    t0 = mcyc;
    rst_n = 1'b1;
    step();
    idle(5);
    chk("rst_nout", 64'(got_c.size()), 64'd1);
    chk("rst_prod", got_at(0), 64'd35);
    chk("rst_latency", 64'(cyc_at(0) - t0), 64'd2);

    // Back-to-back basic products
    clear_log();
    t0 = mcyc;
    issue(32'd1, 32'd2);
    issue(32'd100, 32'd200);
    issue(32'h0000FFFF, 32'h0000FFFF);
    idle(5);
    chk("b2b_nout", 64'(got_c.size()), 64'd3);
    chk("b2b_p0", got_at(0), 64'h2);
    chk("b2b_p1", got_at(1), 64'h4E20);
    chk("b2b_p2", got_at(2), 64'hFFFE0001);
    chk("b2b_latency", 64'(cyc_at(0) - t0), 64'd2);
    chk("b2b_consecutive", 64'(cyc_at(2) - cyc_at(0)), 64'd2);

    // Extreme operands
    clear_log();
    issue(32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(32'h80000000, 32'h00000002);
    idle(5);
`ifdef PM32_SIGNED_EN
    chk("max_prod", got_at(0), 64'h0000000000000001);
    chk("minint_x2", got_at(1), 64'hFFFFFFFF00000000);
`else
    chk("max_prod", got_at(0), 64'hFFFFFFFE00000001);
    chk("minint_x2", got_at(1), 64'h0000000100000000);
`endif

    // Operand changes without in_valid must not disturb the output
    clear_log();
    in_valid = 1'b0;
    repeat (6) begin
      a = $urandom;
      b = $urandom;
      step();
    end
    chk("wiggle_nout", 64'(got_c.size()), 64'd0);
`ifdef PM32_SIGNED_EN
    chk("wiggle_hold", c, 64'hFFFFFFFF00000000);
`else
    chk("wiggle_hold", c, 64'h0000000100000000);
`endif

    // Gaps: result holds across bubbles
    clear_log();
    issue(32'd3, 32'd4);
    idle(2);
    issue(32'd0, 32'hDEADBEEF);
    idle(5);
    chk("gap_nout", 64'(got_c.size()), 64'd2);
    chk("gap_p0", got_at(0), 64'd12);
    chk("gap_p1", got_at(1), 64'd0);
    chk("gap_spacing", 64'(cyc_at(1) - cyc_at(0)), 64'd3);

    // Mid-flight reset flushes the pipe
    issue(32'd6, 32'd7);
    clear_log();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(6);
    chk("flush_nout", 64'(got_c.size()), 64'd0);
    chk("flush_c", c, 64'd0);
    t0 = mcyc;
    issue(32'd9, 32'd9);
    idle(5);
    chk("post_flush_prod", got_at(0), 64'd81);
    chk("post_flush_latency", 64'(cyc_at(0) - t0), 64'd2);

    // Random stream with occasional bubbles, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      in_valid = ($urandom_range(0, 3) != 0);
      step();
    end
    idle(5);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
